// File: rtl/debug_slave_pkg.sv
// -----------------------------------------------------------------------------
// debug_slave_pkg
// Shared definitions for the system-clock side of the CPU debug slave:
//   - default widths for the IR, the DR (sr/jdo), the action bit and the
//     synchroniser depth
//   - NUM_CMD derivation (one pulse line per IR encoding)
//   - command-hold state encoding
//   - parameter legality check used as an elaboration-time assertion
// -----------------------------------------------------------------------------
package debug_slave_pkg;

    localparam int DEF_IR_WIDTH    = 2;
    localparam int DEF_DR_WIDTH    = 38;
    localparam int DEF_ACTION_BIT  = 34;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_SYNC_STAGES = 4;

    typedef enum logic {
        CMD_IDLE = 1'b0,
        CMD_HELD = 1'b1
    } cmd_state_e;

    function automatic int num_cmd(input int ir_width);
        return 1 << ir_width;
    endfunction

    function automatic bit params_ok(input int dr_width, input int action_bit,
                                     input int sync_stages);
        return (action_bit >= 0) && (action_bit < dr_width) &&
               (sync_stages >= MIN_SYNC_STAGES) && (sync_stages <= MAX_SYNC_STAGES);
    endfunction

endpackage

// File: rtl/debug_slave_sysclk_gen_sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Brings an asynchronous level (a virtual-JTAG update state) into the clk
// domain and produces a one-cycle rise indication.
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   async_in  asynchronous level from the tck domain
//   rise      combinational, high for one cycle per armed low-to-high
//             transition of the synchronised level
// -----------------------------------------------------------------------------
module sync_edge_det
    import debug_slave_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   dly_q, dly_d;
    logic                   armed_q, armed_d;
    logic                   synced;

    // fill_q marks which sync stages hold samples taken after reset release.
    // The chain itself resets to 0, so a low level is only trusted for arming
    // once it has travelled the whole chain; otherwise a strobe held high
    // across reset release would look like a fresh rise.
    always_comb begin
        synced  = sync_q[SYNC_STAGES-1];
        sync_d  = {sync_q[SYNC_STAGES-2:0], async_in};
        fill_d  = {fill_q[SYNC_STAGES-2:0], 1'b1};
        dly_d   = synced;
        armed_d = armed_q | (fill_q[SYNC_STAGES-1] & ~synced);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            fill_q  <= '0;
            dly_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            fill_q  <= fill_d;
            dly_q   <= dly_d;
            armed_q <= armed_d;
        end
    end

    assign rise = synced & ~dly_q & armed_q;

endmodule

// File: rtl/debug_slave_sysclk_gen.sv
// -----------------------------------------------------------------------------
// debug_slave_sysclk_gen
// System-clock side of the CPU debug slave. Synchronises the virtual-JTAG
// update-IR / update-DR strobes, captures IR and DR, and turns each accepted
// DR update into a one-cycle per-instruction take_action / take_no_action
// pulse. A single-entry hold (cmd_pending / cmd_ready) guards the captured
// command; updates arriving while it is occupied are dropped and flagged in a
// sticky overflow bit.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   ir_in, sr            tck-domain IR and DR shift register (quasi-static)
//   vs_uir, vs_udr       asynchronous update-IR / update-DR levels
//   cmd_ready            consumer takes the held command
//   ovf_clr              clears overflow
//   jdo, ir_q            captured DR and its paired IR
//   take_action          one-hot pulse at ir_q when jdo[ACTION_BIT]=1
//   take_no_action       one-hot pulse at ir_q when jdo[ACTION_BIT]=0
//   cmd_pending          a command is held awaiting cmd_ready
//   overflow             sticky: an update was dropped while pending
// -----------------------------------------------------------------------------
module debug_slave_sysclk_gen
    import debug_slave_pkg::*;
#(
    parameter int IR_WIDTH    = DEF_IR_WIDTH,
    parameter int DR_WIDTH    = DEF_DR_WIDTH,
    parameter int ACTION_BIT  = DEF_ACTION_BIT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    localparam int NUM_CMD    = num_cmd(IR_WIDTH)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [IR_WIDTH-1:0] ir_in,
    input  logic [DR_WIDTH-1:0] sr,
    input  logic                vs_uir,
    input  logic                vs_udr,
    input  logic                cmd_ready,
    input  logic                ovf_clr,
    output logic [DR_WIDTH-1:0] jdo,
    output logic [IR_WIDTH-1:0] ir_q,
    output logic [NUM_CMD-1:0]  take_action,
    output logic [NUM_CMD-1:0]  take_no_action,
    output logic                cmd_pending,
    output logic                overflow
);

    if (!params_ok(DR_WIDTH, ACTION_BIT, SYNC_STAGES)) begin : g_param_check
        $error("debug_slave_sysclk_gen: need ACTION_BIT < DR_WIDTH and SYNC_STAGES in 2..4");
    end

    logic uir_rise;
    logic udr_rise;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_uir_det (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (vs_uir),
        .rise     (uir_rise)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_udr_det (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (vs_udr),
        .rise     (udr_rise)
    );

    cmd_state_e          state_q, state_d;
    logic [IR_WIDTH-1:0] ir_shadow_q, ir_shadow_d;
    logic [IR_WIDTH-1:0] ir_hold_q, ir_hold_d;
    logic [DR_WIDTH-1:0] jdo_q, jdo_d;
    logic [NUM_CMD-1:0]  take_action_q, take_action_d;
    logic [NUM_CMD-1:0]  take_no_action_q, take_no_action_d;
    logic                overflow_q, overflow_d;

    logic [IR_WIDTH-1:0] ir_sel;
    logic [NUM_CMD-1:0]  cmd_onehot;
    logic                slot_free;
    logic                capture;
    logic                drop;

    always_comb begin
        // A uir rise in the same cycle as the udr rise must win, otherwise the
        // command would be paired with the stale shadow IR.
        ir_sel              = uir_rise ? ir_in : ir_shadow_q;
        cmd_onehot          = '0;
        cmd_onehot[ir_sel]  = 1'b1;

        // The hold slot is free if empty or being emptied this very cycle.
        slot_free = (state_q == CMD_IDLE) || cmd_ready;
        capture   = udr_rise && slot_free;
        drop      = udr_rise && !slot_free;

        ir_shadow_d      = uir_rise ? ir_in : ir_shadow_q;
        jdo_d            = jdo_q;
        ir_hold_d        = ir_hold_q;
        take_action_d    = '0;
        take_no_action_d = '0;
        state_d          = state_q;

        if (capture) begin
            jdo_d     = sr;
            ir_hold_d = ir_sel;
            if (sr[ACTION_BIT]) begin
                take_action_d = cmd_onehot;
            end else begin
                take_no_action_d = cmd_onehot;
            end
            state_d = CMD_HELD;
        end else if ((state_q == CMD_HELD) && cmd_ready) begin
            state_d = CMD_IDLE;
        end

        // Set has priority over clear so a drop is never lost.
        overflow_d = drop || (overflow_q && !ovf_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= CMD_IDLE;
            ir_shadow_q      <= '0;
            ir_hold_q        <= '0;
            jdo_q            <= '0;
            take_action_q    <= '0;
            take_no_action_q <= '0;
            overflow_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            ir_shadow_q      <= ir_shadow_d;
            ir_hold_q        <= ir_hold_d;
            jdo_q            <= jdo_d;
            take_action_q    <= take_action_d;
            take_no_action_q <= take_no_action_d;
            overflow_q       <= overflow_d;
        end
    end

    assign jdo            = jdo_q;
    assign ir_q           = ir_hold_q;
    assign take_action    = take_action_q;
    assign take_no_action = take_no_action_q;
    assign cmd_pending    = (state_q == CMD_HELD);
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_debug_slave_sysclk_gen.sv
module tb_debug_slave_sysclk_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // Default-parameter instance
    logic [1:0]  ir_in0;
    logic [37:0] sr0;
    logic        uir0, udr0, rdy0, clr0;
    logic [37:0] jdo0;
    logic [1:0]  irq0;
    logic [3:0]  ta0, tna0;
    logic        pend0, ovf0;

    // Wide instance: SYNC_STAGES=4, IR_WIDTH=3, DR_WIDTH=40
    logic [2:0]  ir_in1;
    logic [39:0] sr1;
    logic        uir1, udr1, rdy1, clr1;
    logic [39:0] jdo1;
    logic [2:0]  irq1;
    logic [7:0]  ta1, tna1;
    logic        pend1, ovf1;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level reference model
    logic [37:0] m_jdo;
    logic [1:0]  m_irq, m_shadow;
    bit          m_pend, m_ovf;

    debug_slave_sysclk_gen dut0 (
        .clk(clk), .reset_n(reset_n), .ir_in(ir_in0), .sr(sr0),
        .vs_uir(uir0), .vs_udr(udr0), .cmd_ready(rdy0), .ovf_clr(clr0),
        .jdo(jdo0), .ir_q(irq0), .take_action(ta0), .take_no_action(tna0),
        .cmd_pending(pend0), .overflow(ovf0)
    );

    debug_slave_sysclk_gen #(
        .IR_WIDTH(3), .DR_WIDTH(40), .ACTION_BIT(34), .SYNC_STAGES(4)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .ir_in(ir_in1), .sr(sr1),
        .vs_uir(uir1), .vs_udr(udr1), .cmd_ready(rdy1), .ovf_clr(clr1),
        .jdo(jdo1), .ir_q(irq1), .take_action(ta1), .take_no_action(tna1),
        .cmd_pending(pend1), .overflow(ovf1)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, still running want finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_uir0(input logic [1:0] ir);
        ir_in0 = ir;
        uir0   = 1'b1;
        repeat (4) tick();
        uir0 = 1'b0;
        repeat (4) tick();
    endtask

    task automatic pulse_rdy0();
        rdy0 = 1'b1;
        tick();
        rdy0 = 1'b0;
        tick();
    endtask

    task automatic pulse_clr0();
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        tick();
    endtask

    // Raises vs_udr (optionally vs_uir too), drives cmd_ready/ovf_clr for the
    // capture edge, and reports the pulse outputs after edges 2, 3 and 4
    // counted from the first edge that samples vs_udr high.
    task automatic strobe_udr0(input logic [37:0] s, input logic rdy, input logic clr,
                               input bit with_uir, input logic [1:0] ir,
                               output logic [3:0] pre_a, output logic [3:0] pre_n,
                               output logic [3:0] post_a, output logic [3:0] post_n,
                               output logic [3:0] aft_a, output logic [3:0] aft_n);
        sr0  = s;
        udr0 = 1'b1;
        if (with_uir) begin
            ir_in0 = ir;
            uir0   = 1'b1;
        end
        tick();
        tick();
        pre_a = ta0;
        pre_n = tna0;
        rdy0  = rdy;
        clr0  = clr;
        tick();
        post_a = ta0;
        post_n = tna0;
        rdy0   = 1'b0;
        clr0   = 1'b0;
        tick();
        aft_a = ta0;
        aft_n = tna0;
        udr0  = 1'b0;
        uir0  = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ir_in0 = '0; sr0 = '0; uir0 = 0; udr0 = 0; rdy0 = 0; clr0 = 0;
        ir_in1 = '0; sr1 = '0; uir1 = 0; udr1 = 0; rdy1 = 0; clr1 = 0;
        repeat (3) tick();
        n_checks++; if ({jdo0, irq0} !== 40'h0) begin n_fail++; $display("FAIL reset_jdo_irq: got %h want 0", {jdo0, irq0}); end
        n_checks++; if ({ta0, tna0, pend0, ovf0} !== 10'h0) begin n_fail++; $display("FAIL reset_ctrl0: got %b want 0", {ta0, tna0, pend0, ovf0}); end
        n_checks++; if ({jdo1, irq1, ta1, tna1, pend1, ovf1} !== 61'h0) begin n_fail++; $display("FAIL reset_dut1: got %h want 0", {jdo1, irq1, ta1, tna1, pend1, ovf1}); end
        reset_n = 1'b1;
        repeat (6) tick();
        n_checks++; if ({ta0, tna0, pend0} !== 9'h0) begin n_fail++; $display("FAIL post_reset_idle: got %b want 0", {ta0, tna0, pend0}); end
    endtask

    task automatic test_action();
        logic [3:0] pa, pn, a, n, fa, fn;
        strobe_uir0(2'd2);
        strobe_udr0(38'h04_0000_00AB, 1'b0, 1'b0, 1'b0, 2'd0, pa, pn, a, n, fa, fn);
        n_checks++; if ({pa, pn} !== 8'h0) begin n_fail++; $display("FAIL action_early: got %b want 0", {pa, pn}); end
        n_checks++; if (a !== 4'b0100) begin n_fail++; $display("FAIL action_pulse: got %b want 0100", a); end
        n_checks++; if (n !== 4'b0000) begin n_fail++; $display("FAIL action_no_action: got %b want 0000", n); end
        n_checks++; if ({fa, fn} !== 8'h0) begin n_fail++; $display("FAIL action_one_cycle: got %b want 0", {fa, fn}); end
        n_checks++; if (jdo0 !== 38'h04_0000_00AB) begin n_fail++; $display("FAIL action_jdo: got %h want 04000000ab", jdo0); end
        n_checks++; if (irq0 !== 2'd2) begin n_fail++; $display("FAIL action_irq: got %0d want 2", irq0); end
        n_checks++; if (pend0 !== 1'b1) begin n_fail++; $display("FAIL action_pending: got %b want 1", pend0); end
    endtask

    task automatic test_no_action();
        logic [3:0] pa, pn, a, n, fa, fn;
        pulse_rdy0();
        n_checks++; if (pend0 !== 1'b0) begin n_fail++; $display("FAIL ready_release: got %b want 0", pend0); end
        pulse_rdy0();
        n_checks++; if ({pend0, ovf0} !== 2'b00) begin n_fail++; $display("FAIL ready_idle_ignored: got %b want 00", {pend0, ovf0}); end
        strobe_uir0(2'd1);
        strobe_udr0(38'h00_1234_5678, 1'b0, 1'b0, 1'b0, 2'd0, pa, pn, a, n, fa, fn);
        n_checks++; if (n !== 4'b0010) begin n_fail++; $display("FAIL no_action_pulse: got %b want 0010", n); end
        n_checks++; if (a !== 4'b0000) begin n_fail++; $display("FAIL no_action_ta_quiet: got %b want 0000", a); end
        n_checks++; if ({jdo0, irq0, pend0} !== {38'h00_1234_5678, 2'd1, 1'b1}) begin n_fail++; $display("FAIL no_action_state: got %h want %h", {jdo0, irq0, pend0}, {38'h00_1234_5678, 2'd1, 1'b1}); end
    endtask

    task automatic test_overflow();
        logic [3:0] pa, pn, a, n, fa, fn;
        strobe_udr0(38'h1, 1'b0, 1'b0, 1'b0, 2'd0, pa, pn, a, n, fa, fn);
        n_checks++; if ({a, n, fa, fn} !== 16'h0) begin n_fail++; $display("FAIL ovf_no_pulse: got %h want 0", {a, n, fa, fn}); end
        n_checks++; if (jdo0 !== 38'h00_1234_5678) begin n_fail++; $display("FAIL ovf_jdo_kept: got %h want 0012345678", jdo0); end
        n_checks++; if ({ovf0, pend0} !== 2'b11) begin n_fail++; $display("FAIL ovf_set: got %b want 11", {ovf0, pend0}); end
        strobe_udr0(38'h2, 1'b0, 1'b1, 1'b0, 2'd0, pa, pn, a, n, fa, fn);
        n_checks++; if (ovf0 !== 1'b1) begin n_fail++; $display("FAIL ovf_set_beats_clear: got %b want 1", ovf0); end
        pulse_clr0();
        n_checks++; if ({ovf0, pend0} !== 2'b01) begin n_fail++; $display("FAIL ovf_clear: got %b want 01", {ovf0, pend0}); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] pa, pn, a, n, fa, fn;
        strobe_udr0(38'h3F_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 2'd0, pa, pn, a, n, fa, fn);
        n_checks++; if (a !== 4'b0010) begin n_fail++; $display("FAIL b2b_pulse: got %b want 0010", a); end
        n_checks++; if ({jdo0, pend0, ovf0} !== {38'h3F_FFFF_FFFF, 2'b10}) begin n_fail++; $display("FAIL b2b_state: got %h want %h", {jdo0, pend0, ovf0}, {38'h3F_FFFF_FFFF, 2'b10}); end
        // uir and udr rising together: ir_q must take the new IR directly
        strobe_udr0(38'h00_0000_0001, 1'b1, 1'b0, 1'b1, 2'd3, pa, pn, a, n, fa, fn);
        n_checks++; if ({a, n} !== 8'b0000_1000) begin n_fail++; $display("FAIL bypass_pulse: got %b want 00001000", {a, n}); end
        n_checks++; if (irq0 !== 2'd3) begin n_fail++; $display("FAIL bypass_irq: got %0d want 3", irq0); end
    endtask

    task automatic test_reset_held_strobe();
        logic [3:0] pa, pn, a, n, fa, fn;
        logic [3:0] seen;
        udr0    = 1'b1;
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        seen = '0;
        repeat (8) begin
            tick();
            seen = seen | ta0 | tna0;
        end
        n_checks++; if ({seen, pend0} !== 5'b0) begin n_fail++; $display("FAIL held_strobe_no_event: got %b want 0", {seen, pend0}); end
        udr0 = 1'b0;
        repeat (5) tick();
        strobe_udr0(38'h04_0000_0055, 1'b0, 1'b0, 1'b0, 2'd0, pa, pn, a, n, fa, fn);
        n_checks++; if ({a, n} !== 8'b0001_0000) begin n_fail++; $display("FAIL rearm_pulse: got %b want 00010000", {a, n}); end
        // A second update accepted with cmd_ready, then reset while its pulse is up
        sr0  = 38'h00_0000_00C3;
        udr0 = 1'b1;
        tick();
        tick();
        rdy0 = 1'b1;
        tick();
        rdy0 = 1'b0;
        n_checks++; if (tna0 !== 4'b0001) begin n_fail++; $display("FAIL pre_reset_pulse: got %b want 0001", tna0); end
        reset_n = 1'b0;
        #1;
        n_checks++; if ({jdo0, irq0, ta0, tna0, pend0, ovf0} !== 50'h0) begin n_fail++; $display("FAIL async_reset: got %h want 0", {jdo0, irq0, ta0, tna0, pend0, ovf0}); end
        udr0 = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_random();
        logic [3:0]  pa, pn, a, n, fa, fn, exp_a, exp_n;
        logic [63:0] r;
        logic [37:0] s;
        logic [1:0]  ir;
        logic        rdy, clr;
        bit          with_uir, cap;
        int          op;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (6) tick();
        m_jdo = '0; m_irq = '0; m_shadow = '0; m_pend = 0; m_ovf = 0;
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 5);
            ir = 2'($urandom_range(0, 3));
            if (op == 0) begin
                strobe_uir0(ir);
                m_shadow = ir;
                n_checks++; if ({irq0, pend0} !== {m_irq, m_pend}) begin n_fail++; $display("FAIL rand_uir[%0d]: got %b want %b", i, {irq0, pend0}, {m_irq, m_pend}); end
            end else if (op == 1) begin
                pulse_rdy0();
                m_pend = 0;
                n_checks++; if (pend0 !== m_pend) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", i, pend0, m_pend); end
            end else if (op == 2) begin
                pulse_clr0();
                m_ovf = 0;
                n_checks++; if (ovf0 !== m_ovf) begin n_fail++; $display("FAIL rand_clr[%0d]: got %b want %b", i, ovf0, m_ovf); end
            end else begin
                r        = {$urandom(), $urandom()};
                s        = r[37:0];
                rdy      = 1'($urandom_range(0, 1));
                clr      = ($urandom_range(0, 3) == 0);
                with_uir = ($urandom_range(0, 3) == 0);
                strobe_udr0(s, rdy, clr, with_uir, ir, pa, pn, a, n, fa, fn);
                if (with_uir) m_shadow = ir;
                cap   = !m_pend || rdy;
                exp_a = '0;
                exp_n = '0;
                if (cap) begin
                    m_jdo  = s;
                    m_irq  = m_shadow;
                    m_pend = 1;
                    if (s[34]) exp_a[m_irq] = 1'b1;
                    else       exp_n[m_irq] = 1'b1;
                end
                m_ovf = !cap ? 1'b1 : (clr ? 1'b0 : m_ovf);
                n_checks++; if ({pa, pn, a, n, fa, fn} !== {8'h0, exp_a, exp_n, 8'h0}) begin n_fail++; $display("FAIL rand_pulses[%0d]: got %h want %h", i, {pa, pn, a, n, fa, fn}, {8'h0, exp_a, exp_n, 8'h0}); end
                n_checks++; if ({jdo0, irq0, pend0, ovf0} !== {m_jdo, m_irq, m_pend, m_ovf}) begin n_fail++; $display("FAIL rand_state[%0d]: got %h want %h", i, {jdo0, irq0, pend0, ovf0}, {m_jdo, m_irq, m_pend, m_ovf}); end
            end
        end
    endtask

    task automatic test_wide_config();
        logic [7:0] obs [1:7];
        ir_in1 = 3'd7;
        uir1   = 1'b1;
        repeat (6) tick();
        uir1 = 1'b0;
        repeat (6) tick();
        sr1  = 40'h04_0000_00CD;
        udr1 = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            obs[k] = ta1 | tna1;
        end
        udr1 = 1'b0;
        n_checks++; if (obs[4] !== 8'h00) begin n_fail++; $display("FAIL wide_early: got %b want 0", obs[4]); end
        n_checks++; if (obs[5] !== 8'h80) begin n_fail++; $display("FAIL wide_pulse_edge5: got %b want 10000000", obs[5]); end
        n_checks++; if (obs[6] !== 8'h00) begin n_fail++; $display("FAIL wide_one_cycle: got %b want 0", obs[6]); end
        n_checks++; if ({jdo1, irq1, pend1} !== {40'h04_0000_00CD, 3'd7, 1'b1}) begin n_fail++; $display("FAIL wide_state: got %h want %h", {jdo1, irq1, pend1}, {40'h04_0000_00CD, 3'd7, 1'b1}); end
        repeat (6) tick();
    endtask

    initial begin
        test_reset();
        test_action();
        test_no_action();
        test_overflow();
        test_back_to_back();
        test_reset_held_strobe();
        test_wide_config();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
